// File: rtl/text_layer_pkg.sv
// Shared types and constants for the text overlay: colour codes, controller
// states and RAM sizing helpers.
package text_layer_pkg;

  localparam logic [1:0] CLR_WHITE = 2'd0;
  localparam logic [1:0] CLR_BLUE  = 2'd1;
  localparam logic [1:0] CLR_GREEN = 2'd2;
  localparam logic [1:0] CLR_RED   = 2'd3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_WHITE = '{r: 4'hf, g: 4'hf, b: 4'hf};
  localparam rgb_t RGB_BLUE  = '{r: 4'h0, g: 4'h7, b: 4'hf};
  localparam rgb_t RGB_GREEN = '{r: 4'h0, g: 4'hf, b: 4'h0};
  localparam rgb_t RGB_RED   = '{r: 4'hf, g: 4'h0, b: 4'h0};

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] col;
    logic [4:0] ch;
  } wr_req_t;

  function automatic int ram_depth(int rows, int cols);
    return rows * cols;
  endfunction

  function automatic int ram_aw(int rows, int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic rgb_t code_rgb(logic [1:0] code);
    rgb_t c;
    case (code)
      CLR_WHITE: c = RGB_WHITE;
      CLR_BLUE:  c = RGB_BLUE;
      CLR_GREEN: c = RGB_GREEN;
      default:   c = RGB_RED;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_char_ram.sv
// Character store: one write port, one registered read port that returns the
// pre-write contents when both ports hit the same address on one edge.
module text_char_ram #(
  parameter int DEPTH = 140,
  parameter int AW    = 8,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_layer_renderer.sv
// Text overlay for the VGA path: hit-tests the pixel against the character
// grid, fetches glyph bits from the font reader and emits registered RGB.
module text_layer_renderer
  import text_layer_pkg::*;
#(
  parameter int H_ORIGIN  = 128,
  parameter int V_ORIGIN  = 104,
  parameter int ROW_PITCH = 88,
  parameter int NUM_ROWS  = 4,
  parameter int COLS      = 35,
  parameter int GLYPH_W   = 12,
  parameter int GLYPH_H   = 18,
  parameter int BLINK_LOG = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_row,
  input  logic [5:0]            wr_col,
  input  logic [4:0]            wr_char,
  input  logic                  clr_req,
  input  logic [2*NUM_ROWS-1:0] row_color,
  input  logic                  sel_en,
  input  logic [3:0]            sel_row,
  output logic [4:0]            font_char,
  output logic [3:0]            font_x,
  output logic [4:0]            font_y,
  input  logic                  font_bit,
  output logic [3:0]            r,
  output logic [3:0]            g,
  output logic [3:0]            b
);

  localparam int DEPTH  = ram_depth(NUM_ROWS, COLS);
  localparam int AW     = ram_aw(NUM_ROWS, COLS);
  // register stages between the hit test and the colour stage
  localparam int STAGES = 1;

  // ---------------- controller ----------------
  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr, clr_addr_nxt;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [4:0]    ram_wdata;
  wr_req_t       wreq;
  logic          wr_in_range;
  logic [AW-1:0] wr_addr;

  assign wreq        = '{row: wr_row, col: wr_col, ch: wr_char};
  assign wr_in_range = ({1'b0, wreq.row} < 5'(NUM_ROWS)) && ({1'b0, wreq.col} < 7'(COLS));
  assign wr_addr     = AW'(32'(wreq.row) * 32'(COLS) + 32'(wreq.col));

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    wr_ready     = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = clr_addr;
    ram_wdata    = '0;
    case (state)
      S_CLEAR: begin
        ram_we = 1'b1;
        if (clr_req) begin
          clr_addr_nxt = '0;
        end else if (clr_addr == AW'(DEPTH - 1)) begin
          state_nxt    = S_RUN;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end
      S_RUN: begin
        wr_ready = !clr_req;
        if (clr_req) begin
          state_nxt    = S_CLEAR;
          clr_addr_nxt = '0;
        end else if (wr_valid && wr_in_range) begin
          // out-of-range writes complete the handshake but never reach the RAM
          ram_we    = 1'b1;
          ram_waddr = wr_addr;
          ram_wdata = wreq.ch;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // ---------------- blink ----------------
  logic                 origin, origin_q, frame_tick;
  logic [BLINK_LOG-1:0] frame_cnt;

  assign origin     = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign frame_tick = origin && !origin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_q  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      origin_q <= origin;
      if (frame_tick) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // ---------------- P0: hit test ----------------
  logic [9:0]    dh, dv, col_full, row_full, y_full;
  logic [3:0]    x0;
  logic          h_in, v_in, hit0, hl0;
  logic [1:0]    color0;
  logic [AW-1:0] ram_raddr;
  logic [4:0]    ram_rdata;

  assign dh       = h_cnt - 10'(H_ORIGIN);
  assign dv       = v_cnt - 10'(V_ORIGIN);
  assign col_full = dh / 10'(GLYPH_W);
  assign x0       = 4'(dh % 10'(GLYPH_W));
  assign row_full = dv / 10'(ROW_PITCH);
  assign y_full   = dv % 10'(ROW_PITCH);
  assign h_in     = (h_cnt >= 10'(H_ORIGIN)) && (col_full < 10'(COLS));
  assign v_in     = (v_cnt >= 10'(V_ORIGIN)) && (row_full < 10'(NUM_ROWS)) && (y_full < 10'(GLYPH_H));
  assign hit0     = valid && h_in && v_in;
  assign hl0      = sel_en && (10'(sel_row) == row_full) && frame_cnt[BLINK_LOG-1];
  assign ram_raddr = AW'(32'(row_full) * 32'(COLS) + 32'(col_full));

  always_comb begin
    color0 = CLR_WHITE;
    for (int i = 0; i < NUM_ROWS; i++)
      if (row_full == 10'(i)) color0 = row_color[2*i +: 2];
  end

  text_char_ram #(.DEPTH(DEPTH), .AW(AW), .DW(5)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ---------------- P1/P2 pipeline ----------------
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:0]       hl_pipe;
  logic [STAGES:0][1:0]  color_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      hl_pipe    <= '0;
      color_pipe <= '0;
      font_x     <= '0;
      font_y     <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], hit0};
      hl_pipe    <= {hl_pipe[STAGES-1:0], hl0};
      color_pipe <= {color_pipe[STAGES-1:0], color0};
      font_x     <= hit0 ? x0 : 4'd0;
      font_y     <= hit0 ? y_full[4:0] : 5'd0;
    end
  end

  // the RAM output is already the P1 register; gate it so misses request glyph 0
  assign font_char = vld_pipe[0] ? ram_rdata : 5'd0;

  // ---------------- P2 colour, P3 output register ----------------
  rgb_t pix;

  always_comb begin
    pix = RGB_BLACK;
    if (vld_pipe[STAGES] && (font_bit ^ hl_pipe[STAGES]))
      pix = code_rgb(color_pipe[STAGES]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= pix.r;
      g <= pix.g;
      b <= pix.b;
    end
  end

endmodule

// File: tb/tb_text_layer_renderer.sv
// Bench for text_layer_renderer: models the font reader, keeps a shadow of the
// character grid and scoreboards every checked pixel against the 3-clk output.
module tb_text_layer_renderer;

  logic       clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
  logic [9:0] h_cnt = 10'd700, v_cnt = 10'd500;
  logic       wr_valid = 1'b0, wr_ready;
  logic [3:0] wr_row = '0;
  logic [5:0] wr_col = '0;
  logic [4:0] wr_char = '0;
  logic       clr_req = 1'b0;
  logic [7:0] row_color = 8'b11_10_01_00;
  logic       sel_en = 1'b0;
  logic [3:0] sel_row = '0;
  logic [4:0] font_char;
  logic [3:0] font_x;
  logic [4:0] font_y;
  logic       font_bit = 1'b0;
  logic [3:0] r, g, b;

  int n_vec = 0, n_err = 0;
  int frames = 0;
  int mem_sh [140];
  logic drv_chk = 1'b0;

  typedef struct {
    int         h;
    int         v;
    logic [11:0] rgb;
  } exp_t;
  exp_t exp_q [$];

  text_layer_renderer #(.BLINK_LOG(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .clr_req(clr_req), .row_color(row_color), .sel_en(sel_en),
    .sel_row(sel_row), .font_char(font_char), .font_x(font_x), .font_y(font_y),
    .font_bit(font_bit), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  function automatic logic gbit(int c, int x, int y);
    return (c != 0) && (((x + y + c) % 3) == 0);
  endfunction

  // font reader: one-clock registered lookup
  always @(posedge clk) font_bit <= gbit(int'(font_char), int'(font_x), int'(font_y));

  function automatic logic [11:0] rgb_of(logic [1:0] code);
    case (code)
      2'd0: return 12'hfff;
      2'd1: return 12'h07f;
      2'd2: return 12'h0f0;
      default: return 12'hf00;
    endcase
  endfunction

  function automatic logic [11:0] model(int h, int v, logic vl);
    int dh, dv, row, col, x, y;
    logic lit, hl;
    if (!vl || h < 128 || h >= 128 + 35*12 || v < 104) return 12'h000;
    dh = h - 128; dv = v - 104;
    row = dv / 88; y = dv % 88;
    if (row >= 4 || y >= 18) return 12'h000;
    col = dh / 12; x = dh % 12;
    lit = gbit(mem_sh[row*35 + col], x, y);
    hl  = sel_en && (int'(sel_row) == row) && frames[1];
    return (lit ^ hl) ? rgb_of(row_color[2*row +: 2]) : 12'h000;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_px();
    h_cnt = 10'd700; v_cnt = 10'd500; valid = 1'b0; drv_chk = 1'b0;
  endtask

  task automatic drain();
    idle_px();
    repeat (4) step();
  endtask

  task automatic pxh(input int h, input int v, input logic [11:0] want);
    exp_t e;
    h_cnt = 10'(h); v_cnt = 10'(v); valid = 1'b1; drv_chk = 1'b1;
    e.h = h; e.v = v; e.rgb = want;
    exp_q.push_back(e);
    step();
  endtask

  task automatic px(input int h, input int v, input logic vl);
    exp_t e;
    h_cnt = 10'(h); v_cnt = 10'(v); valid = vl; drv_chk = 1'b1;
    e.h = h; e.v = v; e.rgb = model(h, v, vl);
    exp_q.push_back(e);
    step();
  endtask

  task automatic do_wr(input int row, input int col, input int ch);
    idle_px();
    wr_valid = 1'b1; wr_row = 4'(row); wr_col = 6'(col); wr_char = 5'(ch);
    #1;
    chk("wr_ready_handshake", int'(wr_ready), 1);
    step();
    wr_valid = 1'b0;
    if (row < 4 && col < 35) mem_sh[row*35 + col] = ch;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic tick_frame();
    h_cnt = 10'd0; v_cnt = 10'd0; valid = 1'b1; drv_chk = 1'b0;
    repeat (2) step();
    idle_px();
    step();
    frames++;
  endtask

  // monitor: output at cycle k belongs to the pixel driven at cycle k-3
  logic [3:0] hist = '0;
  always @(posedge clk) begin
    exp_t e;
    #2;
    hist = {hist[2:0], drv_chk};
    if (hist[3]) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pix_underflow: got %h want none", {r, g, b});
      end else begin
        e = exp_q.pop_front();
        if ({r, g, b} !== e.rgb) begin
          n_err++;
          $display("FAIL pix(%0d,%0d): got %h want %h", e.h, e.v, {r, g, b}, e.rgb);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 140; i++) mem_sh[i] = 0;

    // reset state
    #12;
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_font", int'({font_char, font_x, font_y}), 0);
    step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("reset_clear_len", n, 140);

    // cleared RAM: whole grid black
    for (int rw = 0; rw < 4; rw++)
      for (int k = 0; k < 12; k++) px(128 + k*37, 104 + rw*88 + (k % 18), 1'b1);
    drain();

    // row 1 col 2 code 13, blue row
    do_wr(1, 2, 13);
    pxh(154, 192, 12'h07f);
    pxh(152, 192, 12'h000);
    pxh(153, 193, 12'h07f);
    pxh(157, 192, 12'h07f);
    pxh(155, 193, 12'h000);
    pxh(163, 209, 12'h000);
    pxh(164, 192, 12'h000);
    pxh(154, 191, 12'h000);
    pxh(154, 210, 12'h000);
    for (int v = 191; v <= 210; v++)
      for (int h = 150; h <= 165; h++) px(h, v, 1'b1);
    px(154, 192, 1'b0);
    drain();

    // last column of the last row, red
    do_wr(3, 34, 7);
    pxh(536, 368, 12'h000);
    pxh(538, 368, 12'hf00);
    pxh(547, 368, 12'hf00);
    pxh(548, 368, 12'h000);
    pxh(545, 385, 12'hf00);
    pxh(547, 385, 12'h000);
    pxh(545, 386, 12'h000);
    drain();

    // out-of-range writes are accepted but dropped (col 40 must not alias row 1 col 5)
    do_wr(7, 2, 31);
    do_wr(0, 40, 9);
    for (int h = 186; h <= 201; h++) px(h, 193, 1'b1);
    pxh(154, 192, 12'h07f);
    drain();

    // write/read collision: display sees the old code on the write edge
    wr_valid = 1'b1; wr_row = 4'd1; wr_col = 6'd2; wr_char = 5'd20;
    pxh(154, 192, 12'h07f);
    wr_valid = 1'b0;
    mem_sh[1*35 + 2] = 20;
    pxh(154, 192, 12'h000);
    pxh(156, 192, 12'h07f);
    drain();

    // blinking highlight on row 0 (white), toggles every 2 frames
    sel_en = 1'b1; sel_row = 4'd0;
    do_wr(0, 0, 5);
    for (int f = 0; f < 6; f++) begin
      pxh(129, 104, frames[1] ? 12'h000 : 12'hfff);
      pxh(128, 104, frames[1] ? 12'hfff : 12'h000);
      for (int h = 128; h < 134; h++) px(h, 105, 1'b1);
      px(156, 192, 1'b1);
      px(127, 104, 1'b1);
      drain();
      tick_frame();
    end
    sel_en = 1'b0;

    // clear during a write burst
    do_wr(2, 3, 11);
    wr_valid = 1'b1; wr_row = 4'd2; wr_col = 6'd4; wr_char = 5'd12;
    clr_req = 1'b1;
    #1;
    chk("clr_drops_ready", int'(wr_ready), 0);
    step();
    clr_req = 1'b0; wr_valid = 1'b0;
    wait_ready(n);
    chk("clr_len", n, 140);
    for (int i = 0; i < 140; i++) mem_sh[i] = 0;
    pxh(156, 192, 12'h000);
    pxh(538, 368, 12'h000);
    pxh(129, 104, 12'h000);
    px(128 + 3*12 + 1, 104 + 2*88 + 1, 1'b1);
    drain();

    // clear pulse in mid-clear restarts the count
    do_wr(1, 2, 13);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (50) step();
    clr_req = 1'b1;
    #1;
    chk("midclr_ready", int'(wr_ready), 0);
    step();
    clr_req = 1'b0;
    wait_ready(n);
    chk("midclr_restart_len", n, 140);
    for (int i = 0; i < 140; i++) mem_sh[i] = 0;
    pxh(154, 192, 12'h000);
    drain();

    // asynchronous reset in the middle of a lit line
    do_wr(1, 2, 13);
    h_cnt = 10'd154; v_cnt = 10'd192; valid = 1'b1; drv_chk = 1'b0;
    repeat (5) step();
    chk("pre_reset_rgb", int'({r, g, b}), 12'h07f);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", int'({r, g, b}), 0);
    chk("async_rst_wr_ready", int'(wr_ready), 0);
    chk("async_rst_font", int'({font_char, font_x, font_y}), 0);
    idle_px();
    step();
    rst_n = 1'b1;
    frames = 0;
    wait_ready(n);
    chk("post_rst_clear_len", n, 140);

    drain();
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
